fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; directly upstream of the ID stage and the hazard detection unit.
- Consumes the hazard unit's `stall` and `ifflush`, and the ID-stage branch resolution (`branch_taken`/`branch_target`).
- Drives a valid/ready instruction-memory request channel.
- Produces `if_id_instr`, `if_id_pc4` and `if_id_valid` for decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard unit: hold PC and IF/ID
ifflush  in  1  hazard unit: squash IF/ID to bubble
branch_taken  in  1  ID-stage redirect request
branch_target  in  ADDR_W  redirect address; [1:0] forced to 0 internally
imem_req  out  1  instruction-memory request valid
imem_addr  out  ADDR_W  request address
imem_ready  in  1  memory accepts request and returns data this cycle
imem_rdata  in  DATA_W  instruction, valid when imem_req&&imem_ready
if_id_instr  out  DATA_W  instruction to ID
if_id_pc4  out  ADDR_W  PC+4 of that instruction
if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_PC, req_addr=RESET_PC, state=IDLE
  - imem_req=0, if_id_instr=0 (NOP), if_id_pc4=0, if_id_valid=0
  - holding buffer cleared
- Reset mid-request drops the request immediately. The memory side must tolerate an abandoned request on reset.
- Memory contract:
  - Transfer = imem_req && imem_ready in the same cycle.
  - Once imem_req is raised, imem_addr stays stable and imem_req stays high until transfer.
  - imem_addr is driven from the req_addr register, never directly from pc.
- pc+4 arithmetic is modulo 2^ADDR_W; 0xFFFF_FFFC+4 wraps to 0.
- State IDLE: imem_req=0; next cycle -> FETCH with req_addr=pc.
- State FETCH: imem_req=1.
  - Transfer, no redirect, stall=0: IF/ID <= {rdata, req_addr+4, valid=1}; pc, req_addr <= pc+4; stay FETCH. Sustains 1 instr/cycle.
  - Transfer, stall=1: rdata and pc+4 go into the 1-entry holding buffer; IF/ID unchanged; -> HOLD.
  - Transfer with branch_taken=1: rdata discarded; pc, req_addr <= target; stay FETCH.
  - No transfer, branch_taken=1: pc <= target; req_addr unchanged; -> KILL.
  - No transfer, no redirect: hold.
- State KILL: imem_req=1 at the old req_addr.
  - On transfer: discard rdata; req_addr <= pc; -> FETCH.
  - A further branch_taken in KILL overwrites pc (last redirect wins).
- State HOLD: imem_req=0; IF/ID holds.
  - branch_taken=1: buffer discarded; pc, req_addr <= target; -> FETCH.
  - Else when stall=0: IF/ID <= buffer with valid=1; pc, req_addr <= pc+4; -> FETCH.
- IF/ID register update priority, highest first:
  1. ifflush=1: instr=0, pc4=0, valid=0, regardless of stall or an arriving instruction.
  2. stall=1: hold.
  3. Load as described above.
  4. Otherwise, if FETCH has no transfer or is in KILL/IDLE: valid=0, instr=0 (bubble).
- ifflush alone does not redirect the PC; only branch_taken changes pc.
- branch_taken with stall=1 simultaneously: redirect still taken; IF/ID held unless ifflush.
- Stall while no request is in flight (FETCH with no transfer): pc is not advanced; stall only affects IF/ID.

Test Plan:
- Reset release, imem_ready=1 constant, imem_rdata=addr-derived, RESET_PC=0 -> imem_addr 0,4,8,12 on consecutive cycles from the first FETCH cycle; if_id_pc4 = 4,8,12 one cycle after each transfer; if_id_valid=1 continuous.
- stall=1 for 3 cycles during streaming at addr 0x10 -> one transfer at 0x10 buffered; imem_req=0 for the remaining stall cycles; IF/ID holds 0x0C's instruction; after stall drops, IF/ID = instr@0x10, pc4=0x14; next request 0x14; no instruction lost or duplicated.
- imem_ready=0 for 4 cycles with branch_taken=1, target=0x100 pulsed in cycle 1 -> imem_addr stays at the old address until ready; that data is discarded (if_id_valid=0); next imem_addr=0x100.
- branch_taken=1 & ifflush=1 with a transfer at 0x20 same cycle -> if_id_valid=0, if_id_instr=0; next imem_addr=0x100; instr@0x20 never reaches IF/ID.
- pc=0xFFFF_FFFC streaming -> next imem_addr=0x0000_0000; if_id_pc4=0.
- rst_n low mid-KILL and mid-HOLD -> all outputs at reset values immediately (async); after release, the first request is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register for the
// 5-stage MIPS pipeline.
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   stall, ifflush  - hazard unit controls (hold / squash IF/ID)
//   branch_taken    - ID-stage redirect request, branch_target is the new PC
//   imem_req/addr   - instruction-memory request (valid/ready handshake)
//   imem_ready      - memory accepts the request and returns data this cycle
//   imem_rdata      - fetched instruction, valid on imem_req && imem_ready
//   if_id_instr     - instruction handed to decode (0 = NOP bubble)
//   if_id_pc4       - PC+4 of that instruction
//   if_id_valid     - IF/ID holds a real instruction
module fetch_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              ifflush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid
);

    // IDLE: first cycle after reset, FETCH: normal request, KILL: waiting to
    // retire an abandoned request whose data must be dropped, HOLD: one
    // fetched instruction parked in the buffer while the pipeline is stalled.
    typedef enum logic [1:0] {IDLE, FETCH, KILL, HOLD} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] req_addr, req_next;
    logic [DATA_W-1:0] buf_instr;
    logic [ADDR_W-1:0] buf_pc4;
    logic              buf_we;
    logic              load_ifid;
    logic [DATA_W-1:0] load_instr;
    logic [ADDR_W-1:0] load_pc4;

    logic              xfer;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] req_plus4;
    logic              unused_target_bits;

    assign xfer               = imem_req & imem_ready;
    assign target             = {branch_target[ADDR_W-1:2], 2'b00};
    assign pc_plus4           = pc + ADDR_W'(4);
    assign req_plus4          = req_addr + ADDR_W'(4);
    assign unused_target_bits = ^branch_target[1:0];
    assign imem_addr          = req_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_next;
        end
    end

    // Once a request is issued req_addr only moves on a transfer, so the
    // address stays stable while imem_req waits for imem_ready.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        req_next   = req_addr;
        buf_we     = 1'b0;
        load_ifid  = 1'b0;
        load_instr = imem_rdata;
        load_pc4   = req_plus4;
        imem_req   = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
                req_next   = pc;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (xfer) begin
                    if (branch_taken) begin
                        pc_next  = target;
                        req_next = target;
                    end else if (stall) begin
                        buf_we     = 1'b1;
                        state_next = HOLD;
                    end else begin
                        load_ifid = 1'b1;
                        pc_next   = pc_plus4;
                        req_next  = pc_plus4;
                    end
                end else if (branch_taken) begin
                    // The in-flight request cannot be withdrawn; remember the
                    // redirect and drop its data when it completes.
                    pc_next    = target;
                    state_next = KILL;
                end
            end
            KILL: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_next = target;
                end
                if (xfer) begin
                    req_next   = branch_taken ? target : pc;
                    state_next = FETCH;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_next    = target;
                    req_next   = target;
                    state_next = FETCH;
                end else if (!stall) begin
                    load_ifid  = 1'b1;
                    load_instr = buf_instr;
                    load_pc4   = buf_pc4;
                    pc_next    = pc_plus4;
                    req_next   = pc_plus4;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_instr <= '0;
            buf_pc4   <= '0;
        end else if (buf_we) begin
            buf_instr <= imem_rdata;
            buf_pc4   <= req_plus4;
        end
    end

    // Flush beats stall beats load; anything else becomes a NOP bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (ifflush) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            if_id_instr <= if_id_instr;
            if_id_pc4   <= if_id_pc4;
            if_id_valid <= if_id_valid;
        end else if (load_ifid) begin
            if_id_instr <= load_instr;
            if_id_pc4   <= load_pc4;
            if_id_valid <= 1'b1;
        end else begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// A request/discard/buffer model predicts the fetch outputs every cycle; a
// set of hand-computed literal checks pins the model at key points.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ifflush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int tests_run;
    int tests_failed;

    fetch_stage #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .ifflush      (ifflush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory content derived from the address; never zero.
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    assign imem_rdata = instr_at(imem_addr);

    // Model: an outstanding request (or none), whether its data is to be
    // dropped, an optional parked instruction, and the IF/ID contents.
    logic        m_req;
    logic [31:0] m_req_addr;
    logic [31:0] m_pc;
    logic        m_discard;
    logic        m_bufv;
    logic [31:0] m_buf_instr;
    logic [31:0] m_buf_pc4;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_xfer;
    logic        m_load;
    logic [31:0] m_ld_instr;
    logic [31:0] m_ld_pc4;
    logic [31:0] m_tgt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req      = 1'b0;
            m_req_addr = 32'h0;
            m_pc       = 32'h0;
            m_discard  = 1'b0;
            m_bufv     = 1'b0;
            m_valid    = 1'b0;
            m_instr    = 32'h0;
            m_pc4      = 32'h0;
        end else begin
            m_xfer     = m_req && imem_ready;
            m_load     = 1'b0;
            m_ld_instr = 32'h0;
            m_ld_pc4   = 32'h0;
            m_tgt      = branch_target & 32'hFFFF_FFFC;
            if (!m_req && !m_bufv) begin
                m_req      = 1'b1;
                m_req_addr = m_pc;
                m_discard  = 1'b0;
            end else if (m_bufv) begin
                if (branch_taken) begin
                    m_bufv     = 1'b0;
                    m_pc       = m_tgt;
                    m_req      = 1'b1;
                    m_req_addr = m_tgt;
                end else if (!stall) begin
                    m_load     = 1'b1;
                    m_ld_instr = m_buf_instr;
                    m_ld_pc4   = m_buf_pc4;
                    m_bufv     = 1'b0;
                    m_pc       = m_pc + 32'd4;
                    m_req      = 1'b1;
                    m_req_addr = m_pc;
                end
            end else if (m_xfer) begin
                if (m_discard) begin
                    if (branch_taken) m_pc = m_tgt;
                    m_req_addr = m_pc;
                    m_discard  = 1'b0;
                end else if (branch_taken) begin
                    m_pc       = m_tgt;
                    m_req_addr = m_tgt;
                end else if (stall) begin
                    m_bufv      = 1'b1;
                    m_buf_instr = instr_at(m_req_addr);
                    m_buf_pc4   = m_req_addr + 32'd4;
                    m_req       = 1'b0;
                end else begin
                    m_load     = 1'b1;
                    m_ld_instr = instr_at(m_req_addr);
                    m_ld_pc4   = m_req_addr + 32'd4;
                    m_pc       = m_req_addr + 32'd4;
                    m_req_addr = m_pc;
                end
            end else if (branch_taken) begin
                m_pc      = m_tgt;
                m_discard = 1'b1;
            end
            if (ifflush) begin
                m_valid = 1'b0;
                m_instr = 32'h0;
                m_pc4   = 32'h0;
            end else if (!stall) begin
                m_valid = m_load;
                m_instr = m_load ? m_ld_instr : 32'h0;
                m_pc4   = m_load ? m_ld_pc4 : 32'h0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check_output("model_req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req) check_output("model_addr", imem_addr, m_req_addr);
        check_output("model_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        check_output("model_instr", if_id_instr, m_instr);
        if (m_valid) check_output("model_pc4", if_id_pc4, m_pc4);
    end

    // Drive one cycle of inputs, then wait until the following negedge.
    task automatic apply_stimulus(input logic s, input logic f, input logic b,
                                  input logic [31:0] t, input logic r);
        stall         = s;
        ifflush       = f;
        branch_taken  = b;
        branch_target = t;
        imem_ready    = r;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check_output({tag, "_valid"}, {31'b0, if_id_valid}, 32'd0);
        check_output({tag, "_instr"}, if_id_instr, 32'd0);
        check_output({tag, "_pc4"}, if_id_pc4, 32'd0);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        ifflush       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ready    = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        check_output("reset_addr", imem_addr, 32'h0);
        rst_n = 1'b1;

        // Streaming from RESET_PC
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("first_req", {31'b0, imem_req}, 32'd1);
        check_output("first_addr", imem_addr, 32'h0);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("stream_addr4", imem_addr, 32'h4);
        check_output("stream_pc4_4", if_id_pc4, 32'h4);
        check_output("stream_instr0", if_id_instr, 32'hC0DE_0001);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("stream_pc4_8", if_id_pc4, 32'h8);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("stream_pc4_c", if_id_pc4, 32'hC);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("stream_addr10", imem_addr, 32'h10);

        // Three-cycle stall while the request at 0x10 completes
        apply_stimulus(1, 0, 0, 0, 1);
        check_output("stall_req_low", {31'b0, imem_req}, 32'd0);
        check_output("stall_hold_pc4", if_id_pc4, 32'h10);
        apply_stimulus(1, 0, 0, 0, 1);
        apply_stimulus(1, 0, 0, 0, 1);
        check_output("stall_hold_instr", if_id_instr, instr_at(32'hC));
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("unstall_instr", if_id_instr, 32'hC0DE_0011);
        check_output("unstall_pc4", if_id_pc4, 32'h14);
        check_output("unstall_addr", imem_addr, 32'h14);

        // Redirect while memory is not ready
        apply_stimulus(0, 0, 1, 32'h100, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("kill_addr_stable", imem_addr, 32'h14);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("kill_dropped", {31'b0, if_id_valid}, 32'd0);
        check_output("kill_new_addr", imem_addr, 32'h100);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("kill_resume_pc4", if_id_pc4, 32'h104);

        // Branch plus flush on the same cycle as a transfer at 0x20
        apply_stimulus(0, 0, 1, 32'h22, 1);
        check_output("redir_addr20", imem_addr, 32'h20);
        apply_stimulus(0, 1, 1, 32'h100, 1);
        check_output("flush_valid", {31'b0, if_id_valid}, 32'd0);
        check_output("flush_instr", if_id_instr, 32'd0);
        check_output("flush_addr", imem_addr, 32'h100);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("after_flush_instr", if_id_instr, 32'hC0DE_0101);

        // Address wrap
        apply_stimulus(0, 0, 1, 32'hFFFF_FFF8, 1);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("wrap_addr_fc", imem_addr, 32'hFFFF_FFFC);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("wrap_addr_0", imem_addr, 32'h0);
        check_output("wrap_pc4_0", if_id_pc4, 32'h0);
        check_output("wrap_valid", {31'b0, if_id_valid}, 32'd1);

        // Asynchronous reset in the middle of KILL
        apply_stimulus(0, 0, 1, 32'h200, 0);
        check_output("kill_req_high", {31'b0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_kill");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("rst_kill_first_addr", imem_addr, 32'h0);

        // Asynchronous reset in the middle of HOLD
        apply_stimulus(1, 0, 0, 0, 1);
        check_output("hold_req_low", {31'b0, imem_req}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("rst_hold_first_addr", imem_addr, 32'h0);
        check_output("rst_hold_first_req", {31'b0, imem_req}, 32'd1);

        // Mixed directed pattern of stalls, flushes, redirects and wait states
        for (int i = 0; i < 80; i++) begin
            apply_stimulus((i % 7) == 3, (i % 13) == 9, (i % 11) == 6,
                           32'(i) * 32'h44 + 32'h3, (i % 5) != 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
